// File: rtl/x_readback_streamer.sv
// Readback engine: takes a (channel, address, length) request, reads words
// from NUM_CH sources and streams each word to a UART as DATA_W/8 bytes.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_req_valid/o_req_accept, i_req_ch, i_req_addr, i_req_len
//   o_ren (one-hot), o_raddr, i_rdata (packed per channel)
//   o_tx_data/o_tx_valid/i_tx_accept, o_busy
module x_readback_streamer #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 8,
  parameter int READ_LAT  = 1,
  parameter int MSB_FIRST = 0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_accept,
  input  logic [CH_W-1:0]          i_req_ch,
  input  logic [ADDR_W-1:0]        i_req_addr,
  input  logic [LEN_W-1:0]         i_req_len,
  output logic [NUM_CH-1:0]        o_ren,
  output logic [ADDR_W-1:0]        o_raddr,
  input  logic [NUM_CH*DATA_W-1:0] i_rdata,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_accept,
  output logic                     o_busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_left;
  logic [LAT_W-1:0]  r_lat;
  logic [BC_W-1:0]   r_bcnt;
  logic [DATA_W-1:0] r_shift;

  logic [DATA_W-1:0] w_rdata_sel;
  logic              w_lat_last;
  logic              w_byte_last;
  logic [7:0]        w_byte;

  // Out-of-range channels fall through to the filler pattern.
  always_comb begin
    w_rdata_sel = {BYTES{8'hAA}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == CH_W'(c)) begin
        w_rdata_sel = i_rdata[c*DATA_W +: DATA_W];
      end
    end
  end

  assign w_lat_last  = (r_lat == LAT_W'(READ_LAT - 1));
  assign w_byte_last = (r_bcnt == BC_W'(BYTES - 1));
  assign w_byte      = (MSB_FIRST != 0) ? r_shift[DATA_W-1 -: 8]
                                        : r_shift[7:0];

  always_comb begin
    w_state_nxt  = r_state;
    o_req_accept = 1'b0;
    o_ren        = '0;
    o_raddr      = '0;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;
    o_busy       = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        o_req_accept = i_rst;
        if (i_req_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_raddr = r_addr;
        for (int c = 0; c < NUM_CH; c++) begin
          o_ren[c] = (r_ch == CH_W'(c));
        end
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_lat_last) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = w_byte;
        if (i_tx_accept && w_byte_last) begin
          w_state_nxt = (r_left != '0) ? S_ISSUE : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_addr  <= '0;
      r_left  <= '0;
      r_lat   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_ch   <= i_req_ch;
            r_addr <= i_req_addr;
            r_left <= i_req_len;
          end
        end
        S_ISSUE: r_lat <= '0;
        S_WAIT: begin
          r_lat <= r_lat + LAT_W'(1);
          if (w_lat_last) begin
            r_shift <= w_rdata_sel;
            r_bcnt  <= '0;
          end
        end
        S_SEND: begin
          if (i_tx_accept) begin
            r_bcnt  <= r_bcnt + BC_W'(1);
            r_shift <= (MSB_FIRST != 0) ? (r_shift << 8)
                                        : (r_shift >> 8);
            // Address wraps naturally at 2^ADDR_W.
            if (w_byte_last && r_left != '0) begin
              r_left <= r_left - LEN_W'(1);
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_readback_streamer.sv
// Self-checking bench for x_readback_streamer: three instances cover the
// default build, a 3-channel build and an MSB-first READ_LAT=3 build.
module tb_x_readback_streamer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic logic [31:0] src_word(input int c, input logic [10:0] a);
    if (c == 2 && a == 11'h010) return 32'hDDCCBBAA;
    return {8'h10 + 8'(c), 5'b0, a, 8'h3C};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- instance A: defaults ----------------
  logic         a_req_v, a_req_acc;
  logic [1:0]   a_req_ch;
  logic [10:0]  a_req_addr, a_raddr, a_addr_d;
  logic [7:0]   a_req_len, a_txd;
  logic [3:0]   a_ren, a_ren_d;
  logic [127:0] a_rdata;
  logic         a_txv, a_txa, a_busy;

  x_readback_streamer u_a (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(a_req_v), .o_req_accept(a_req_acc),
    .i_req_ch(a_req_ch), .i_req_addr(a_req_addr), .i_req_len(a_req_len),
    .o_ren(a_ren), .o_raddr(a_raddr), .i_rdata(a_rdata),
    .o_tx_data(a_txd), .o_tx_valid(a_txv), .i_tx_accept(a_txa),
    .o_busy(a_busy)
  );

  always_ff @(posedge clk) begin
    a_ren_d  <= a_ren;
    a_addr_d <= a_raddr;
  end

  always_comb begin
    for (int c = 0; c < 4; c++)
      a_rdata[c*32 +: 32] = a_ren_d[c] ? src_word(c, a_addr_d) : 32'hEEEEEEEE;
  end

  // ---------------- instance B: 3 channels ----------------
  logic        b_req_v, b_req_acc;
  logic [1:0]  b_req_ch;
  logic [10:0] b_req_addr, b_raddr, b_addr_d;
  logic [7:0]  b_req_len, b_txd;
  logic [2:0]  b_ren, b_ren_d;
  logic [95:0] b_rdata;
  logic        b_txv, b_txa, b_busy;

  x_readback_streamer #(.NUM_CH(3)) u_b (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(b_req_v), .o_req_accept(b_req_acc),
    .i_req_ch(b_req_ch), .i_req_addr(b_req_addr), .i_req_len(b_req_len),
    .o_ren(b_ren), .o_raddr(b_raddr), .i_rdata(b_rdata),
    .o_tx_data(b_txd), .o_tx_valid(b_txv), .i_tx_accept(b_txa),
    .o_busy(b_busy)
  );

  always_ff @(posedge clk) begin
    b_ren_d  <= b_ren;
    b_addr_d <= b_raddr;
  end

  always_comb begin
    for (int c = 0; c < 3; c++)
      b_rdata[c*32 +: 32] = b_ren_d[c] ? src_word(c, b_addr_d) : 32'hEEEEEEEE;
  end

  // ---------------- instance C: MSB first, READ_LAT=3 ----------------
  logic         c_req_v, c_req_acc;
  logic [1:0]   c_req_ch;
  logic [10:0]  c_req_addr, c_raddr, c_a1, c_a2, c_a3;
  logic [7:0]   c_req_len, c_txd;
  logic [3:0]   c_ren, c_r1, c_r2, c_r3;
  logic [127:0] c_rdata;
  logic         c_txv, c_txa, c_busy;

  x_readback_streamer #(.MSB_FIRST(1), .READ_LAT(3)) u_c (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(c_req_v), .o_req_accept(c_req_acc),
    .i_req_ch(c_req_ch), .i_req_addr(c_req_addr), .i_req_len(c_req_len),
    .o_ren(c_ren), .o_raddr(c_raddr), .i_rdata(c_rdata),
    .o_tx_data(c_txd), .o_tx_valid(c_txv), .i_tx_accept(c_txa),
    .o_busy(c_busy)
  );

  always_ff @(posedge clk) begin
    c_r1 <= c_ren; c_r2 <= c_r1; c_r3 <= c_r2;
    c_a1 <= c_raddr; c_a2 <= c_a1; c_a3 <= c_a2;
  end

  always_comb begin
    for (int c = 0; c < 4; c++)
      c_rdata[c*32 +: 32] = c_r3[c] ? src_word(c, c_a3) : 32'hEEEEEEEE;
  end

  // ---------------- A accept driver ----------------
  logic       acc_auto, a_man;
  logic [7:0] acc_pat;
  logic [2:0] acc_ph;

  initial begin
    a_txa  = 1'b0;
    acc_ph = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_auto) begin
        a_txa  = acc_pat[acc_ph];
        acc_ph = acc_ph + 3'd1;
      end else begin
        a_txa = a_man;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [7:0]  a_bytes[$];
  logic [3:0]  a_ren_q[$];
  logic [10:0] a_raddr_q[$];
  int          a_first_v, a_fall, a_last_acc;
  logic        p_v, p_a, p_rst, p_busy;
  logic [7:0]  p_d;

  logic [7:0]  b_bytes[$];
  logic [2:0]  b_ren_q[$];
  logic [7:0]  c_bytes[$];
  int          c_acc_q[$];
  int          c_rise_q[$];
  int          c_bad;
  logic        c_pv;

  initial begin
    p_v = 0; p_a = 0; p_rst = 0; p_busy = 0; p_d = 0; c_pv = 0; c_bad = 0;
    forever begin
      @(negedge clk);
      if (a_txv && a_txa) begin
        a_bytes.push_back(a_txd);
        a_last_acc = cyc;
      end
      if (a_txv && a_first_v < 0) a_first_v = cyc;
      if (a_ren != 4'd0) begin
        a_ren_q.push_back(a_ren);
        a_raddr_q.push_back(a_raddr);
      end
      if (p_busy && !a_busy) a_fall = cyc;
      if (p_v && !p_a && p_rst) begin
        chk("hold_valid", a_txv, 1);
        chk("hold_data", a_txd, p_d);
      end
      p_v = a_txv; p_a = a_txa; p_rst = rst_n; p_busy = a_busy; p_d = a_txd;

      if (b_txv && b_txa) b_bytes.push_back(b_txd);
      if (b_ren != 3'd0) b_ren_q.push_back(b_ren);

      if (c_txv && c_txa) c_bytes.push_back(c_txd);
      if (c_req_v && c_req_acc) c_acc_q.push_back(cyc);
      if (c_txv && !c_pv) c_rise_q.push_back(cyc);
      if (c_busy && c_req_acc) c_bad++;
      c_pv = c_txv;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- helpers for A ----------------
  int a_acc_cyc;

  task automatic clear_a();
    a_bytes.delete();
    a_ren_q.delete();
    a_raddr_q.delete();
    a_first_v  = -1;
    a_fall     = -1;
    a_last_acc = -1;
  endtask

  task automatic start_a(input logic [1:0] ch, input logic [10:0] ad,
                         input logic [7:0] ln);
    int k;
    @(posedge clk); #1;
    a_req_v = 1; a_req_ch = ch; a_req_addr = ad; a_req_len = ln;
    k = 0;
    tick();
    while (!a_req_acc && k < 100) begin tick(); k++; end
    chk("req_taken", a_req_acc, 1);
    a_acc_cyc = cyc;
    @(posedge clk); #1;
    a_req_v = 0; a_req_ch = ~ch; a_req_addr = ~ad; a_req_len = ~ln;
  endtask

  task automatic wait_idle_a();
    int k;
    k = 0;
    tick();
    while (a_busy && k < 400) begin tick(); k++; end
    chk("a_done", a_busy, 0);
  endtask

  function automatic logic [31:0] a_word(input int w);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++)
      if (4*w + b < a_bytes.size()) r[8*b +: 8] = a_bytes[4*w + b];
    return r;
  endfunction

  typedef struct {
    logic [1:0]  ch;
    logic [10:0] addr;
    logic [7:0]  len;
    logic [7:0]  pat;
    logic [31:0] w_first;
    logic [31:0] w_last;
  } vec_t;

  vec_t        tbl[5];
  vec_t        v;
  int          n_w, mism, k;
  logic [10:0] ea;
  logic [31:0] ew;

  initial begin
    tbl[0] = '{2'd2, 11'h010, 8'd0, 8'hFF, 32'hDDCCBBAA, 32'hDDCCBBAA};
    tbl[1] = '{2'd2, 11'h7FE, 8'd2, 8'hFF, 32'h1207FE3C, 32'h1200003C};
    tbl[2] = '{2'd0, 11'h123, 8'd1, 8'hB7, 32'h1001233C, 32'h1001243C};
    tbl[3] = '{2'd3, 11'h7FF, 8'd0, 8'hFF, 32'h1307FF3C, 32'h1307FF3C};
    tbl[4] = '{2'd1, 11'h000, 8'd3, 8'h5B, 32'h1100003C, 32'h1100033C};

    n_checks = 0; n_errors = 0;
    rst_n = 0; acc_auto = 0; a_man = 0; acc_pat = 8'hFF;
    a_req_v = 0; a_req_ch = 0; a_req_addr = 0; a_req_len = 0;
    b_req_v = 0; b_req_ch = 0; b_req_addr = 0; b_req_len = 0; b_txa = 0;
    c_req_v = 0; c_req_ch = 0; c_req_addr = 0; c_req_len = 0; c_txa = 0;
    clear_a();

    repeat (3) tick();
    chk("rst_ren", a_ren, 0);
    chk("rst_raddr", a_raddr, 0);
    chk("rst_txv", a_txv, 0);
    chk("rst_txd", a_txd, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_accept", a_req_acc, 0);
    chk("rst_busy_bc", {b_busy, c_busy}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    chk("idle_accept", a_req_acc, 1);

    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      clear_a();
      acc_pat  = v.pat;
      acc_auto = 1;
      start_a(v.ch, v.addr, v.len);
      wait_idle_a();
      n_w = int'(v.len) + 1;
      chk("first_valid_lat", a_first_v - a_acc_cyc, 3);
      chk("byte_count", a_bytes.size(), 4 * n_w);
      chk("ren_count", a_ren_q.size(), (v.ch == 2'd3) ? n_w : n_w);
      for (int w = 0; w < n_w; w++) begin
        if (w < a_ren_q.size()) begin
          ea = v.addr + 11'(w);
          chk("ren_onehot", a_ren_q[w], 4'b0001 << v.ch);
          chk("raddr", a_raddr_q[w], ea);
        end
      end
      chk("first_word", a_word(0), v.w_first);
      chk("last_word", a_word(n_w - 1), v.w_last);
      mism = 0;
      for (int w = 0; w < n_w; w++) begin
        ew = src_word(int'(v.ch), v.addr + 11'(w));
        for (int b = 0; b < 4; b++) begin
          if (4*w + b < a_bytes.size()) begin
            if (a_bytes[4*w + b] != ew[8*b +: 8]) mism++;
          end else begin
            mism++;
          end
        end
      end
      chk("stream", mism, 0);
      chk("busy_fall", a_fall - a_last_acc, 1);
    end

    // Stall on byte 1 for five cycles.
    acc_auto = 0; a_man = 0;
    clear_a();
    start_a(2'd2, 11'h010, 8'd0);
    k = 0;
    while (!a_txv && k < 50) begin tick(); k++; end
    chk("t3_valid", a_txv, 1);
    @(posedge clk); a_man = 1;
    tick();
    chk("t3_b0", a_txd, 8'hAA);
    @(posedge clk); a_man = 0;
    repeat (5) begin
      tick();
      chk("t3_hold_v", a_txv, 1);
      chk("t3_hold_d", a_txd, 8'hBB);
    end
    @(posedge clk); a_man = 1;
    wait_idle_a();
    chk("t3_count", a_bytes.size(), 4);
    chk("t3_word", a_word(0), 32'hDDCCBBAA);

    // Reset after the second byte of a burst.
    clear_a();
    acc_pat = 8'hFF; acc_auto = 1;
    start_a(2'd1, 11'h100, 8'd3);
    k = 0;
    while (a_bytes.size() < 2 && k < 50) begin tick(); k++; end
    @(posedge clk);
    acc_auto = 0; a_man = 0;
    #1 rst_n = 0;
    tick();
    chk("t5_accept_in_rst", a_req_acc, 0);
    tick();
    chk("t5_ren", a_ren, 0);
    chk("t5_raddr", a_raddr, 0);
    chk("t5_txv", a_txv, 0);
    chk("t5_txd", a_txd, 0);
    chk("t5_busy", a_busy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) tick();
    chk("t5_no_more_bytes", a_bytes.size(), 2);
    clear_a();
    acc_auto = 1;
    start_a(2'd0, 11'h7FF, 8'd0);
    wait_idle_a();
    chk("t5_count", a_bytes.size(), 4);
    chk("t5_word", a_word(0), 32'h1007FF3C);
    chk("t5_lat", a_first_v - a_acc_cyc, 3);

    // NUM_CH=3: invalid channel, then a valid one.
    @(posedge clk); #1;
    b_txa = 1; b_req_v = 1; b_req_ch = 2'd3; b_req_addr = 11'h005; b_req_len = 0;
    k = 0; tick();
    while (!b_req_acc && k < 50) begin tick(); k++; end
    @(posedge clk); #1; b_req_v = 0;
    k = 0; tick();
    while (b_busy && k < 50) begin tick(); k++; end
    chk("b_ren_none", b_ren_q.size(), 0);
    chk("b_count", b_bytes.size(), 4);
    if (b_bytes.size() == 4)
      chk("b_fill", {b_bytes[3], b_bytes[2], b_bytes[1], b_bytes[0]},
          32'hAAAAAAAA);
    b_bytes.delete();
    @(posedge clk); #1;
    b_req_v = 1; b_req_ch = 2'd1; b_req_addr = 11'h020;
    k = 0; tick();
    while (!b_req_acc && k < 50) begin tick(); k++; end
    @(posedge clk); #1; b_req_v = 0;
    k = 0; tick();
    while (b_busy && k < 50) begin tick(); k++; end
    chk("b_ren_count", b_ren_q.size(), 1);
    if (b_ren_q.size() == 1) chk("b_ren_ch1", b_ren_q[0], 3'b010);
    chk("b_count2", b_bytes.size(), 4);
    if (b_bytes.size() == 4)
      chk("b_word", {b_bytes[3], b_bytes[2], b_bytes[1], b_bytes[0]},
          32'h1100203C);

    // MSB first, READ_LAT=3, request held through busy.
    @(posedge clk); #1;
    c_txa = 1; c_req_v = 1; c_req_ch = 2'd2; c_req_addr = 11'h010; c_req_len = 0;
    k = 0;
    while (c_acc_q.size() < 1 && k < 50) begin tick(); k++; end
    @(posedge clk); #1;
    c_req_ch = 2'd1; c_req_addr = 11'h030;
    k = 0;
    while (c_acc_q.size() < 2 && k < 100) begin tick(); k++; end
    @(posedge clk); #1; c_req_v = 0;
    k = 0; tick();
    while ((c_busy || c_bytes.size() < 8) && k < 100) begin tick(); k++; end
    chk("c_acc_count", c_acc_q.size(), 2);
    chk("c_busy_accept", c_bad, 0);
    chk("c_count", c_bytes.size(), 8);
    if (c_bytes.size() == 8)
      chk("c_stream", {c_bytes[0], c_bytes[1], c_bytes[2], c_bytes[3],
                       c_bytes[4], c_bytes[5], c_bytes[6], c_bytes[7]},
          64'hDDCCBBAA_1100303C);
    if (c_acc_q.size() == 2 && c_rise_q.size() == 2) begin
      chk("c_lat1", c_rise_q[0] - c_acc_q[0], 5);
      chk("c_lat2", c_rise_q[1] - c_acc_q[1], 5);
      chk("c_held_gap", c_acc_q[1] - c_acc_q[0], 9);
    end else begin
      chk("c_events", {c_acc_q.size(), c_rise_q.size()}, {32'd2, 32'd2});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
